avalon_burst_arbiter: RTL and testbench

Two-port Avalon-MM burst arbiter that shares one downstream SDRAM master port between the instruction-side and data-side cache refill/write-back masters. Each cache's burst master connects to one upstream slave port. The arbiter grants whole bursts round-robin and holds the grant until every beat of the granted burst completes. It sits between the cache masters and the memory controller / interconnect.

---
 rtl/avalon_arb_pkg.sv | 16 +
 rtl/arb_rr2.sv | 18 +
 rtl/avalon_burst_arbiter.sv | 150 +++++++++++++++
 tb/tb_avalon_burst_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-port Avalon-MM burst arbiter.
package avalon_arb_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CMD  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin pick; the "last served" register lives in the parent.
module arb_rr2
    import avalon_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // Port D wins when it is the only requester, or both request and I was served last.
    always_comb begin
        grant = PORT_I;
        if (req[1] && (!req[0] || last == PORT_I)) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/avalon_burst_arbiter.sv
// Shares one downstream Avalon-MM burst master between the I-cache and D-cache
// refill masters, granting whole bursts round-robin.
module avalon_burst_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BURST_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [ADDR_WIDTH-1:0]  s0_address,
    input  logic [BURST_WIDTH-1:0] s0_burstcount,
    input  logic                   s0_read,
    input  logic                   s0_write,
    input  logic [DATA_WIDTH-1:0]  s0_writedata,
    output logic                   s0_waitrequest,
    output logic [DATA_WIDTH-1:0]  s0_readdata,
    output logic                   s0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]  s1_address,
    input  logic [BURST_WIDTH-1:0] s1_burstcount,
    input  logic                   s1_read,
    input  logic                   s1_write,
    input  logic [DATA_WIDTH-1:0]  s1_writedata,
    output logic                   s1_waitrequest,
    output logic [DATA_WIDTH-1:0]  s1_readdata,
    output logic                   s1_readdatavalid,

    output logic [ADDR_WIDTH-1:0]  m_address,
    output logic [BURST_WIDTH-1:0] m_burstcount,
    output logic                   m_read,
    output logic                   m_write,
    output logic [DATA_WIDTH-1:0]  m_writedata,
    input  logic                   m_waitrequest,
    input  logic [DATA_WIDTH-1:0]  m_readdata,
    input  logic                   m_readdatavalid
);

    state_t                 state;
    logic                   grant;
    logic                   last;
    logic [BURST_WIDTH-1:0] beats_left;

    logic [1:0]             req;
    logic                   pick;
    logic                   pick_write;
    logic [BURST_WIDTH-1:0] pick_bc;
    logic                   sel;
    logic                   g_read;
    logic                   g_write;
    logic                   rd_beat;
    logic                   rd_accept;
    logic                   wr_accept;
    logic                   last_beat;
    logic                   gnt_wait;

    assign req = {s1_read | s1_write, s0_read | s0_write};

    arb_rr2 u_rr (
        .req   (req),
        .last  (last),
        .grant (pick)
    );

    assign pick_write = (pick == PORT_D) ? s1_write      : s0_write;
    assign pick_bc    = (pick == PORT_D) ? s1_burstcount : s0_burstcount;

    // Datapath follows the granted port, or port I while idle.
    assign sel     = (state == ST_IDLE) ? PORT_I : grant;
    assign g_read  = (sel == PORT_D) ? s1_read  : s0_read;
    assign g_write = (sel == PORT_D) ? s1_write : s0_write;

    assign rd_beat   = m_readdatavalid && (state == ST_RD_CMD || state == ST_RD_DATA);
    assign rd_accept = m_read  && !m_waitrequest;
    assign wr_accept = m_write && !m_waitrequest;
    assign last_beat = (beats_left == BURST_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= PORT_I;
            last       <= PORT_D;
            beats_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant      <= pick;
                        last       <= pick;
                        beats_left <= (pick_bc == '0) ? BURST_WIDTH'(1) : pick_bc;
                        state      <= pick_write ? ST_WR : ST_RD_CMD;
                    end
                end
                ST_RD_CMD: begin
                    if (rd_beat) begin
                        beats_left <= beats_left - BURST_WIDTH'(1);
                    end
                    if (rd_beat && last_beat) begin
                        state <= ST_IDLE;
                    end else if (rd_accept) begin
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_beat) begin
                        beats_left <= beats_left - BURST_WIDTH'(1);
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_accept) begin
                        beats_left <= beats_left - BURST_WIDTH'(1);
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command, data and handshake paths are combinational; nothing is buffered.
    always_comb begin
        m_address    = (sel == PORT_D) ? s1_address    : s0_address;
        m_burstcount = (sel == PORT_D) ? s1_burstcount : s0_burstcount;
        m_writedata  = (sel == PORT_D) ? s1_writedata  : s0_writedata;
        m_read       = (state == ST_RD_CMD) && g_read;
        m_write      = (state == ST_WR) && g_write;

        gnt_wait         = (state == ST_RD_DATA) ? 1'b1 : m_waitrequest;
        s0_waitrequest   = 1'b1;
        s1_waitrequest   = 1'b1;
        if (state != ST_IDLE) begin
            if (grant == PORT_I) begin
                s0_waitrequest = gnt_wait;
            end else begin
                s1_waitrequest = gnt_wait;
            end
        end
        s0_readdatavalid = rd_beat && (grant == PORT_I);
        s1_readdatavalid = rd_beat && (grant == PORT_D);
        s0_readdata      = m_readdata;
        s1_readdata      = m_readdata;
    end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Directed self-checking bench for avalon_burst_arbiter.
module tb_avalon_burst_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 7;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] s0_address,   s1_address;
    logic [BW-1:0] s0_burstcount, s1_burstcount;
    logic          s0_read, s0_write, s1_read, s1_write;
    logic [31:0]   s0_writedata, s1_writedata;
    logic          s0_waitrequest, s1_waitrequest;
    logic [31:0]   s0_readdata, s1_readdata;
    logic          s0_readdatavalid, s1_readdatavalid;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_burstcount;
    logic          m_read, m_write;
    logic [31:0]   m_writedata;
    logic          m_waitrequest;
    logic [31:0]   m_readdata;
    logic          m_readdatavalid;

    int n_cmp = 0;
    int n_err = 0;

    avalon_burst_arbiter #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s0_address       (s0_address),
        .s0_burstcount    (s0_burstcount),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_writedata     (s0_writedata),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_burstcount    (s1_burstcount),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .m_address        (m_address),
        .m_burstcount     (m_burstcount),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_writedata      (m_writedata),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_address = '0; s0_burstcount = '0; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
        s1_address = '0; s1_burstcount = '0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    int cnt0, cnt1, acc, k, stray;
    int pat [7] = '{1, 0, 1, 0, 0, 1, 0};

    initial begin
        // Reset values, with requests present to show they are stalled
        clear_inputs();
        rst_n = 1'b0;
        s0_read = 1'b1; s1_write = 1'b1; m_readdatavalid = 1'b1;
        #1;
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_s0_wait", 32'(s0_waitrequest), 32'd1);
        check("rst_s1_wait", 32'(s1_waitrequest), 32'd1);
        check("rst_s0_rdv", 32'(s0_readdatavalid), 32'd0);
        check("rst_s1_rdv", 32'(s1_readdatavalid), 32'd0);

        // Single 64-beat read on port 1
        do_reset();
        s1_address = 32'h0000_1000; s1_burstcount = 7'd64; s1_read = 1'b1;
        #1;
        check("rd1_idle_m_read", 32'(m_read), 32'd0);
        step();
        check("rd1_m_read", 32'(m_read), 32'd1);
        check("rd1_m_addr", m_address, 32'h0000_1000);
        check("rd1_m_bc", 32'(m_burstcount), 32'd64);
        check("rd1_s1_wait", 32'(s1_waitrequest), 32'd0);
        check("rd1_s0_wait", 32'(s0_waitrequest), 32'd1);
        step();
        s1_read = 1'b0;
        check("rd1_data_s1_wait", 32'(s1_waitrequest), 32'd1);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 64; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata = 32'hD000_0000 + 32'(i);
            #1;
            if (s0_readdatavalid) cnt0++;
            if (s1_readdatavalid) cnt1++;
            if (i == 5) begin
                check("rd1_s1_rdata", s1_readdata, 32'hD000_0005);
                check("rd1_s0_rdata_bcast", s0_readdata, 32'hD000_0005);
            end
            step();
        end
        m_readdatavalid = 1'b0;
        #1;
        check("rd1_s1_beats", 32'(cnt1), 32'd64);
        check("rd1_s0_beats", 32'(cnt0), 32'd0);
        check("rd1_end_s1_wait", 32'(s1_waitrequest), 32'd1);
        s1_read = 1'b1;
        #1;
        check("rd1_end_idle_m_read", 32'(m_read), 32'd0);
        s1_read = 1'b0;

        // Simultaneous read on port 0 and write on port 1 from reset
        do_reset();
        s0_address = 32'h0000_2000; s0_burstcount = 7'd16; s0_read = 1'b1;
        s1_address = 32'h0000_3000; s1_burstcount = 7'd16; s1_write = 1'b1;
        step();
        check("sim_m_read", 32'(m_read), 32'd1);
        check("sim_m_addr0", m_address, 32'h0000_2000);
        step();
        s0_read = 1'b0;
        cnt1 = 0;
        for (int i = 0; i < 16; i++) begin
            m_readdatavalid = 1'b1;
            #1;
            if (!s1_waitrequest) cnt1++;
            step();
        end
        m_readdatavalid = 1'b0;
        #1;
        check("sim_s1_wait_low_cnt", 32'(cnt1), 32'd0);
        check("sim_gap_m_write", 32'(m_write), 32'd0);
        check("sim_gap_s1_wait", 32'(s1_waitrequest), 32'd1);
        step();
        check("sim_wr_m_write", 32'(m_write), 32'd1);
        check("sim_wr_m_addr", m_address, 32'h0000_3000);
        check("sim_wr_s1_wait", 32'(s1_waitrequest), 32'd0);
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            s1_writedata = 32'h0000_0100 + 32'(i);
            #1;
            if (m_write && !m_waitrequest && m_writedata == 32'h0000_0100 + 32'(i)) acc++;
            step();
        end
        s1_write = 1'b0;
        #1;
        check("sim_wr_accepted", 32'(acc), 32'd16);
        check("sim_wr_end_m_write", 32'(m_write), 32'd0);

        // 4-beat write on port 0 with stalls
        do_reset();
        s0_address = 32'h0000_0040; s0_burstcount = 7'd4; s0_write = 1'b1;
        s0_writedata = 32'h0000_00A0; m_waitrequest = 1'b1;
        step();
        k = 0;
        for (int i = 0; i < 7; i++) begin
            m_waitrequest = 1'(pat[i]);
            #1;
            check($sformatf("wr4_s0_wait_%0d", i), 32'(s0_waitrequest), 32'(pat[i]));
            if (m_write && !m_waitrequest) begin
                check($sformatf("wr4_data_%0d", k), m_writedata, 32'h0000_00A0 + 32'(k));
                k++;
            end
            step();
            s0_writedata = 32'h0000_00A0 + 32'(k);
        end
        s0_write = 1'b0;
        m_waitrequest = 1'b0;
        #1;
        check("wr4_accepted", 32'(k), 32'd4);
        check("wr4_end_s0_wait", 32'(s0_waitrequest), 32'd1);
        s0_write = 1'b1;
        #1;
        check("wr4_end_m_write", 32'(m_write), 32'd0);
        s0_write = 1'b0;

        // Continuous requests from both ports alternate grants
        do_reset();
        s0_address = 32'h0000_0100; s0_burstcount = 7'd2; s0_read = 1'b1;
        s1_address = 32'h0000_0200; s1_burstcount = 7'd2; s1_read = 1'b1;
        for (int b = 0; b < 6; b++) begin
            step();
            check($sformatf("alt_addr_%0d", b), m_address, (b % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
            step();
            m_readdatavalid = 1'b1;
            #1;
            check($sformatf("alt_rdv_%0d", b),
                  32'({s1_readdatavalid, s0_readdatavalid}), (b % 2 == 1) ? 32'd2 : 32'd1);
            step();
            step();
            m_readdatavalid = 1'b0;
        end
        s0_read = 1'b0; s1_read = 1'b0;

        // Reset during beat 10 of a 64-beat read
        do_reset();
        s0_address = 32'h0000_0500; s0_burstcount = 7'd64; s0_read = 1'b1;
        step();
        step();
        s0_read = 1'b0;
        for (int i = 0; i < 9; i++) begin
            m_readdatavalid = 1'b1;
            step();
        end
        #1;
        check("mrst_beat10_pre", 32'(s0_readdatavalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_s0_rdv", 32'(s0_readdatavalid), 32'd0);
        check("mrst_s0_wait", 32'(s0_waitrequest), 32'd1);
        check("mrst_s1_wait", 32'(s1_waitrequest), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s0_readdatavalid || s1_readdatavalid) stray++;
        end
        m_readdatavalid = 1'b0;
        check("mrst_stray_beats", 32'(stray), 32'd0);

        // Port 0 read+write together, burstcount 0: one-beat write first
        do_reset();
        s0_address = 32'h0000_0700; s0_burstcount = 7'd0;
        s0_read = 1'b1; s0_write = 1'b1; s0_writedata = 32'h0000_CAFE;
        step();
        check("rw_m_write", 32'(m_write), 32'd1);
        check("rw_m_read", 32'(m_read), 32'd0);
        check("rw_m_wdata", m_writedata, 32'h0000_CAFE);
        step();
        s0_write = 1'b0;
        #1;
        check("rw_idle_s0_wait", 32'(s0_waitrequest), 32'd1);
        check("rw_idle_m_write", 32'(m_write), 32'd0);
        check("rw_idle_m_read", 32'(m_read), 32'd0);
        step();
        check("rw_read_granted", 32'(m_read), 32'd1);
        check("rw_read_s0_wait", 32'(s0_waitrequest), 32'd0);
        s0_read = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
